// File: rtl/conv2d_requant_serializer.sv
// Requantizes a captured PIX_PER_CLK x COUT accumulator block and streams it out one pixel per beat.
// Optional CONV_REQ_ZERO_POINT_EN adds a signed zero_point input applied before saturation.

module conv2d_requant_lane #(
    parameter int SUM_W   = 32,
    parameter int BIAS_W  = 32,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 5,
    parameter int OUT_W   = 8
) (
    input  logic signed [SUM_W-1:0]   acc,
    input  logic signed [BIAS_W-1:0]  bias,
    input  logic        [MULT_W-1:0]  mult,
    input  logic        [SHIFT_W-1:0] shift,
    input  logic                      relu_en,
    input  logic signed [OUT_W-1:0]   zp,
    output logic        [OUT_W-1:0]   q
);
    localparam int AW = (SUM_W > BIAS_W) ? SUM_W : BIAS_W;
    localparam int VW = AW + 1;
    localparam int MW = VW + MULT_W + 1;
    localparam logic signed [MW+1:0] SAT_HI = (MW+2)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [MW+1:0] SAT_LO = ~SAT_HI;

    logic signed [VW-1:0] v;
    logic signed [MW-1:0] m;
    logic        [MW-1:0] rnd;
    logic signed [MW:0]   s;
    logic signed [MW:0]   r;
    logic signed [MW+1:0] rz;

    always_comb begin
        v   = VW'(acc) + VW'(bias);
        m   = MW'(v) * $signed(MW'(mult));
        rnd = '0;
        if (shift != '0)
            rnd = {{(MW-1){1'b0}}, 1'b1} << (shift - 1'b1);
        // one guard bit keeps the rounding add from wrapping
        s   = $signed({m[MW-1], m}) + $signed({1'b0, rnd});
        r   = s >>> shift;
        if (relu_en && r[MW])
            r = '0;
        rz  = $signed({r[MW], r}) + (MW+2)'(zp);
        if (rz > SAT_HI)
            q = SAT_HI[OUT_W-1:0];
        else if (rz < SAT_LO)
            q = SAT_LO[OUT_W-1:0];
        else
            q = rz[OUT_W-1:0];
    end
endmodule

module conv2d_requant_serializer #(
    parameter int PIX_PER_CLK = 8,
    parameter int COUT        = 16,
    parameter int SUM_W       = 32,
    parameter int BIAS_W      = 32,
    parameter int MULT_W      = 16,
    parameter int SHIFT_W     = 5,
    parameter int OUT_W       = 8,
    localparam int PW         = $clog2(PIX_PER_CLK)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [PIX_PER_CLK-1:0][COUT-1:0][SUM_W-1:0] in_data,
    input  logic [COUT-1:0][BIAS_W-1:0]              bias,
    input  logic [COUT-1:0][MULT_W-1:0]              mult,
    input  logic [COUT-1:0][SHIFT_W-1:0]             shift,
    input  logic                                     relu_en,
`ifdef CONV_REQ_ZERO_POINT_EN
    input  logic signed [OUT_W-1:0]                  zero_point,
`endif
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [COUT-1:0][OUT_W-1:0]               out_data,
    output logic [PW-1:0]                            out_pix,
    output logic                                     out_last,
    output logic                                     busy
);
    localparam logic [PW-1:0] LAST = PW'(PIX_PER_CLK - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
    state_t state, state_nxt;

    logic [PIX_PER_CLK-1:0][COUT-1:0][SUM_W-1:0] blk;
    logic [COUT-1:0][OUT_W-1:0] lane_q;
    logic signed [OUT_W-1:0] zp;
    logic [PW-1:0] load_pix;
    logic accept, load_en, done;

`ifdef CONV_REQ_ZERO_POINT_EN
    assign zp = zero_point;
`else
    assign zp = '0;
`endif

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD;
            LOAD:    state_nxt = SEND;
            SEND:    if (out_ready && out_pix == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // next beat is requantized in the same edge the current one is taken
    always_comb begin
        load_en  = 1'b0;
        done     = 1'b0;
        load_pix = out_pix + 1'b1;
        case (state)
            LOAD: begin
                load_en  = 1'b1;
                load_pix = '0;
            end
            SEND: begin
                load_en = out_ready && (out_pix != LAST);
                done    = out_ready && (out_pix == LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) blk <= in_data;
    end

    for (genvar o = 0; o < COUT; o++) begin : g_lane
        conv2d_requant_lane #(
            .SUM_W(SUM_W), .BIAS_W(BIAS_W), .MULT_W(MULT_W),
            .SHIFT_W(SHIFT_W), .OUT_W(OUT_W)
        ) u_lane (
            .acc(blk[load_pix][o]), .bias(bias[o]), .mult(mult[o]),
            .shift(shift[o]), .relu_en(relu_en), .zp(zp), .q(lane_q[o])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_pix   <= '0;
            out_last  <= 1'b0;
        end else if (load_en) begin
            out_valid <= 1'b1;
            out_data  <= lane_q;
            out_pix   <= load_pix;
            out_last  <= (load_pix == LAST);
        end else if (done) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_conv2d_requant_serializer.sv
// Randomized bench for conv2d_requant_serializer against a plain-arithmetic requant model.
// Build with CONV_REQ_ZERO_POINT_EN to also exercise the zero_point input.

module tb_conv2d_requant_serializer;
    localparam int PIX = 8, COUT = 16, SUM_W = 32, BIAS_W = 32, MULT_W = 16, SHIFT_W = 5, OUT_W = 8;
    localparam int PW = $clog2(PIX);

    logic clk = 0, rst = 1, in_valid = 0, relu_en = 0, out_ready = 0;
    logic in_ready, out_valid, out_last, busy;
    logic [PIX-1:0][COUT-1:0][SUM_W-1:0] in_data = '0;
    logic [COUT-1:0][BIAS_W-1:0] bias = '0;
    logic [COUT-1:0][MULT_W-1:0] mult = '0;
    logic [COUT-1:0][SHIFT_W-1:0] shift = '0;
    logic [COUT-1:0][OUT_W-1:0] out_data;
    logic [PW-1:0] out_pix;
    logic signed [OUT_W-1:0] zp_val = '0;
`ifdef CONV_REQ_ZERO_POINT_EN
    logic signed [OUT_W-1:0] zero_point;
    assign zero_point = zp_val;
`endif

    int vecs = 0, errs = 0;
    logic [COUT-1:0][OUT_W-1:0] exp_blk [PIX];

    always #5 clk = ~clk;

    conv2d_requant_serializer #(
        .PIX_PER_CLK(PIX), .COUT(COUT), .SUM_W(SUM_W), .BIAS_W(BIAS_W),
        .MULT_W(MULT_W), .SHIFT_W(SHIFT_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .bias(bias), .mult(mult), .shift(shift), .relu_en(relu_en),
`ifdef CONV_REQ_ZERO_POINT_EN
        .zero_point(zero_point),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pix(out_pix), .out_last(out_last), .busy(busy)
    );

    function automatic logic [OUT_W-1:0] ref_q(longint acc, longint b, longint mu, int sh, bit relu, longint zp);
        longint r, hi, lo;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -hi - 1;
        r = (acc + b) * mu;
        if (sh > 0) r = (r + (longint'(1) << (sh - 1))) >>> sh;
        if (relu && r < 0) r = 0;
        r = r + zp;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r[OUT_W-1:0];
    endfunction

    task automatic calc_exp();
        for (int p = 0; p < PIX; p++)
            for (int o = 0; o < COUT; o++)
                exp_blk[p][o] = ref_q(longint'($signed(in_data[p][o])), longint'($signed(bias[o])),
                                      longint'(mult[o]), int'(shift[o]), relu_en, longint'(zp_val));
    endtask

    task automatic rand_cfg(input bit wide);
        for (int o = 0; o < COUT; o++) begin
            bias[o]  = wide ? BIAS_W'($urandom) : BIAS_W'($urandom_range(0, 400) - 200);
            mult[o]  = wide ? MULT_W'($urandom) : MULT_W'($urandom_range(0, 600));
            shift[o] = SHIFT_W'(wide ? $urandom_range(0, 31) : $urandom_range(0, 12));
        end
    endtask

    task automatic rand_data(input bit wide);
        for (int p = 0; p < PIX; p++)
            for (int o = 0; o < COUT; o++)
                in_data[p][o] = wide ? SUM_W'($urandom) : SUM_W'($urandom_range(0, 8000) - 4000);
    endtask

    // returns at the falling edge right after the accepting edge
    task automatic push_block(output bit ok);
        ok = 0;
        in_valid = 1;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                @(negedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        vecs++;
        if ({out_valid, out_last, busy, in_ready} !== 4'b0 || out_data !== '0 || out_pix !== '0) begin
            errs++;
            $display("FAIL reset: valid=%b last=%b busy=%b in_ready=%b pix=%0d data=%h, want all 0",
                     out_valid, out_last, busy, in_ready, out_pix, out_data);
        end
        rst = 0;
        #1;
        vecs++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_release: in_ready=%b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_directed();
        bit ok;
        int got;
        logic [3:0][OUT_W-1:0] want;
        rand_cfg(0);
        rand_data(0);
        for (int p = 0; p < PIX; p++) begin
            in_data[p][0] = SUM_W'(1000);
            in_data[p][1] = SUM_W'(5);
            in_data[p][2] = SUM_W'(-5);
            in_data[p][3] = SUM_W'(-100);
        end
        bias[0] = 24; mult[0] = 1; shift[0] = 3;
        for (int o = 1; o < 4; o++) begin bias[o] = 0; mult[o] = 1; shift[o] = 1; end
        mult[3] = 3;
        out_ready = 1;
        for (int pass = 0; pass < 2; pass++) begin
            relu_en = (pass == 1);
            want = (pass == 1) ? {8'h00, 8'h00, 8'h03, 8'h7f} : {8'h80, 8'hfe, 8'h03, 8'h7f};
            calc_exp();
            push_block(ok);
            vecs++;
            if (!ok) begin errs++; $display("FAIL directed_accept: accepted=%b want 1", ok); end
            got = 0;
            for (int c = 0; c < 40 && got < PIX; c++) begin
                @(negedge clk);
                if (out_valid && out_ready) begin
                    vecs++;
                    if (out_pix !== PW'(got) || out_data !== exp_blk[got] || out_last !== (got == PIX - 1)) begin
                        errs++;
                        $display("FAIL directed_beat%0d: pix=%0d last=%b data=%h, want pix=%0d last=%b data=%h",
                                 got, out_pix, out_last, out_data, got, (got == PIX - 1), exp_blk[got]);
                    end
                    vecs++;
                    if (out_data[3:0] !== want) begin
                        errs++;
                        $display("FAIL directed_const relu=%b: ch3..0=%h want %h", relu_en, out_data[3:0], want);
                    end
                    got++;
                end
            end
            vecs++;
            if (got != PIX) begin errs++; $display("FAIL directed_count: beats=%0d want %0d", got, PIX); end
        end
        relu_en = 0;
    endtask

    task automatic test_random();
        bit ok;
        int got;
        for (int b = 0; b < 8; b++) begin
            rand_cfg(b[0]);
            rand_data(b[1]);
            relu_en = $urandom_range(0, 1) == 1;
            calc_exp();
            push_block(ok);
            vecs++;
            if (!ok) begin errs++; $display("FAIL random_accept blk%0d: accepted=%b want 1", b, ok); end
            got = 0;
            for (int c = 0; c < 200 && got < PIX; c++) begin
                @(negedge clk);
                out_ready = $urandom_range(0, 9) < 7;
                if (out_valid && out_ready) begin
                    vecs++;
                    if (out_pix !== PW'(got) || out_data !== exp_blk[got] || out_last !== (got == PIX - 1)) begin
                        errs++;
                        $display("FAIL random blk%0d beat%0d: pix=%0d last=%b data=%h, want pix=%0d last=%b data=%h",
                                 b, got, out_pix, out_last, out_data, got, (got == PIX - 1), exp_blk[got]);
                    end
                    got++;
                end
            end
            vecs++;
            if (got != PIX) begin errs++; $display("FAIL random_count blk%0d: beats=%0d want %0d", b, got, PIX); end
            @(negedge clk);
        end
        out_ready = 1;
        relu_en = 0;
    endtask

    task automatic test_back_to_back();
        int got, nblk, last_acc;
        bit renew;
        got = 0; nblk = 0; last_acc = 0; renew = 0;
        rand_cfg(0);
        rand_data(0);
        out_ready = 1;
        in_valid = 1;
        for (int c = 0; c < 36; c++) begin
            if (renew) begin
                rand_data(0);
                renew = 0;
                if (nblk == 3) in_valid = 0;
            end
            if (out_valid) begin
                vecs++;
                if (got >= PIX || out_pix !== PW'(got) || out_data !== exp_blk[got % PIX] || out_last !== (got == PIX - 1)) begin
                    errs++;
                    $display("FAIL b2b blk%0d beat%0d: pix=%0d last=%b data=%h, want pix=%0d last=%b data=%h",
                             nblk, got, out_pix, out_last, out_data, got, (got == PIX - 1), exp_blk[got % PIX]);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                if (nblk > 0) begin
                    vecs++;
                    if (got != PIX || c - last_acc != PIX + 2) begin
                        errs++;
                        $display("FAIL b2b_period blk%0d: beats=%0d period=%0d, want beats=%0d period=%0d",
                                 nblk, got, c - last_acc, PIX, PIX + 2);
                    end
                end
                calc_exp();
                last_acc = c; got = 0; nblk++; renew = 1;
            end
            @(negedge clk);
        end
        in_valid = 0;
        vecs++;
        if (nblk != 3 || got != PIX) begin
            errs++;
            $display("FAIL b2b_total: blocks=%0d last_beats=%0d, want 3 and %0d", nblk, got, PIX);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int got, stall;
        rand_cfg(0);
        rand_data(0);
        calc_exp();
        out_ready = 1;
        push_block(ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL bp_accept: accepted=%b want 1", ok); end
        got = 0; stall = 3;
        for (int c = 0; c < 60 && got < PIX; c++) begin
            @(negedge clk);
            if (out_valid && out_pix == 2 && stall > 0) begin
                out_ready = 0;
                stall--;
                vecs++;
                if (out_pix !== 2 || out_data !== exp_blk[2] || in_ready !== 1'b0 || busy !== 1'b1) begin
                    errs++;
                    $display("FAIL bp_hold: pix=%0d data=%h in_ready=%b busy=%b, want pix=2 data=%h in_ready=0 busy=1",
                             out_pix, out_data, in_ready, busy, exp_blk[2]);
                end
            end else begin
                out_ready = 1;
                if (out_valid) begin
                    vecs++;
                    if (out_pix !== PW'(got) || out_data !== exp_blk[got] || out_last !== (got == PIX - 1)) begin
                        errs++;
                        $display("FAIL bp_beat%0d: pix=%0d last=%b data=%h, want pix=%0d last=%b data=%h",
                                 got, out_pix, out_last, out_data, got, (got == PIX - 1), exp_blk[got]);
                    end
                    got++;
                end
            end
        end
        vecs++;
        if (got != PIX || stall != 0) begin
            errs++;
            $display("FAIL bp_count: beats=%0d stalls_left=%0d, want %0d and 0", got, stall, PIX);
        end
        repeat (3) begin
            @(negedge clk);
            vecs++;
            if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_extra_beat: out_valid=%b want 0", out_valid); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok, hit;
        int got;
        rand_cfg(0);
        rand_data(0);
        calc_exp();
        out_ready = 1;
        push_block(ok);
        hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            if (out_valid && out_pix == 4) begin
                rst = 1;
                hit = 1;
            end
        end
        vecs++;
        if (!ok || !hit) begin errs++; $display("FAIL rstmid_reach: accepted=%b beat4_seen=%b want 1 1", ok, hit); end
        @(negedge clk);
        vecs++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_data !== '0 || out_pix !== '0) begin
            errs++;
            $display("FAIL rstmid_state: valid=%b busy=%b in_ready=%b pix=%0d data=%h, want 0 0 0 0 0",
                     out_valid, busy, in_ready, out_pix, out_data);
        end
        rst = 0;
        #1;
        vecs++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL rstmid_ready: in_ready=%b want 1", in_ready); end
        repeat (3) begin
            @(negedge clk);
            vecs++;
            if (out_valid !== 1'b0) begin errs++; $display("FAIL rstmid_stale_beat: out_valid=%b want 0", out_valid); end
        end
        rand_data(0);
        calc_exp();
        push_block(ok);
        got = 0;
        for (int c = 0; c < 40 && got < PIX; c++) begin
            @(negedge clk);
            if (out_valid) begin
                vecs++;
                if (out_pix !== PW'(got) || out_data !== exp_blk[got]) begin
                    errs++;
                    $display("FAIL rstmid_next beat%0d: pix=%0d data=%h, want pix=%0d data=%h",
                             got, out_pix, out_data, got, exp_blk[got]);
                end
                got++;
            end
        end
        vecs++;
        if (!ok || got != PIX) begin errs++; $display("FAIL rstmid_next_count: beats=%0d want %0d", got, PIX); end
    endtask

`ifdef CONV_REQ_ZERO_POINT_EN
    task automatic test_zero_point();
        bit ok;
        int got;
        zp_val = -10;
        rand_data(0);
        for (int o = 0; o < COUT; o++) begin
            bias[o] = 0; mult[o] = 1; shift[o] = 0;
            in_data[0][o] = SUM_W'(40);
            in_data[1][o] = SUM_W'(200);
        end
        calc_exp();
        push_block(ok);
        got = 0;
        for (int c = 0; c < 40 && got < PIX; c++) begin
            @(negedge clk);
            if (out_valid) begin
                vecs++;
                if (out_data !== exp_blk[got]) begin
                    errs++;
                    $display("FAIL zp beat%0d: data=%h want %h", got, out_data, exp_blk[got]);
                end
                if (got < 2) begin
                    vecs++;
                    if (out_data[0] !== ((got == 0) ? 8'd30 : 8'd127)) begin
                        errs++;
                        $display("FAIL zp_const beat%0d: ch0=%0d want %0d", got, $signed(out_data[0]), (got == 0) ? 30 : 127);
                    end
                end
                got++;
            end
        end
        vecs++;
        if (!ok || got != PIX) begin errs++; $display("FAIL zp_count: beats=%0d want %0d", got, PIX); end
        zp_val = 0;
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef CONV_REQ_ZERO_POINT_EN
        test_zero_point();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
